// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and RAM pin encodings for the single-port RAM
// initiator (ram_ctrl).
//   state_t        controller FSM states (ST_INIT is only reachable when the
//                  design is built with RAM_CTRL_INIT_EN)
//   RAM_EN_ACTIVE  level of ram_en_n that enables the RAM
//   RAM_OP_WRITE   ram_wr level for a write
//   RAM_OP_READ    ram_wr level for a read
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_INIT  = 3'd5
  } state_t;

  localparam logic RAM_EN_ACTIVE = 1'b0;
  localparam logic RAM_OP_WRITE  = 1'b0;
  localparam logic RAM_OP_READ   = 1'b1;

endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response handshake bundle between a local master and
// ram_ctrl.
//   req_valid/req_ready  request handshake (master -> controller)
//   req_write            1=write, 0=read
//   req_addr, req_wdata  request address / write data
//   rsp_valid/rsp_ready  read-response handshake (controller -> master)
//   rsp_rdata            read data, held while rsp_valid
// Modports: master (request side), slave (controller side).
interface ram_ctrl_if #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 2
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator for a small single-port RAM with active-low enable,
// ram_wr=0 write / ram_wr=1 read, and read data registered one clock after
// the access. Requests arrive on a valid/ready port; read data leaves on a
// valid/ready response port.
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   bus            ram_ctrl_if.slave request/response handshakes
//   init_done      1 once the controller accepts requests
//   ram_en_n       RAM enable (active low), registered
//   ram_wr         RAM op (0=write, 1=read), registered
//   ram_add        RAM address, registered
//   ram_w_data     RAM write data, registered
//   ram_r_data     RAM registered read data
// Build option: RAM_CTRL_INIT_EN adds an INIT sweep after reset that writes
// INIT_VAL to every word before the first request is accepted.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 2
`ifdef RAM_CTRL_INIT_EN
  ,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_ctrl_if.slave         bus,
  output logic              init_done,
  output logic              ram_en_n,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

`ifdef RAM_CTRL_INIT_EN
  localparam int     DEPTH     = 1 << ADDR_W;
  localparam int     CNT_W     = ADDR_W + 1;
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t            state, state_n;
  logic              rdy_q, rdy_n;
  logic              rsp_vld_q, rsp_vld_n;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_n;
  logic              en_n_n, wr_n;
  logic [ADDR_W-1:0] add_n;
  logic [DATA_W-1:0] wdat_n;
  logic              req_hs, rsp_hs;

`ifdef RAM_CTRL_INIT_EN
  logic [CNT_W-1:0]  cnt, cnt_n;
`endif

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rsp_dat_q;

  // req_ready is a register, so a handshake is only possible in IDLE.
  assign req_hs = bus.req_valid & rdy_q;
  assign rsp_hs = rsp_vld_q & bus.rsp_ready;

  // Next-state and next-value of every registered output. RAM pins default
  // to disabled so an enable pulse lasts exactly one cycle.
  always_comb begin
    state_n   = state;
    rdy_n     = 1'b0;
    rsp_vld_n = rsp_vld_q;
    rsp_dat_n = rsp_dat_q;
    en_n_n    = ~RAM_EN_ACTIVE;
    wr_n      = RAM_OP_READ;
    add_n     = ram_add;
    wdat_n    = ram_w_data;
`ifdef RAM_CTRL_INIT_EN
    cnt_n     = cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (req_hs) begin
          en_n_n = RAM_EN_ACTIVE;
          add_n  = bus.req_addr;
          if (bus.req_write) begin
            state_n = ST_WRITE;
            wr_n    = RAM_OP_WRITE;
            wdat_n  = bus.req_wdata;
          end else begin
            state_n = ST_READ;
            wr_n    = RAM_OP_READ;
          end
        end else begin
          rdy_n = 1'b1;
        end
      end
      ST_WRITE: begin
        state_n = ST_IDLE;
        rdy_n   = 1'b1;
      end
      ST_READ: begin
        state_n = ST_CAPT;
      end
      ST_CAPT: begin
        // RAM read data is valid now, one clock after the READ access.
        rsp_vld_n = 1'b1;
        rsp_dat_n = ram_r_data;
        state_n   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rsp_vld_n = 1'b0;
          rdy_n     = 1'b1;
          state_n   = ST_IDLE;
        end
      end
`ifdef RAM_CTRL_INIT_EN
      ST_INIT: begin
        en_n_n = RAM_EN_ACTIVE;
        wr_n   = RAM_OP_WRITE;
        add_n  = cnt[ADDR_W-1:0];
        wdat_n = INIT_VAL;
        cnt_n  = cnt + 1'b1;
        if (cnt == CNT_W'(DEPTH - 1)) begin
          state_n = ST_IDLE;
          rdy_n   = 1'b1;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      rdy_q      <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      ram_en_n   <= ~RAM_EN_ACTIVE;
      ram_wr     <= RAM_OP_READ;
      ram_add    <= '0;
      ram_w_data <= '0;
`ifdef RAM_CTRL_INIT_EN
      cnt        <= '0;
      init_done  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      rdy_q      <= rdy_n;
      rsp_vld_q  <= rsp_vld_n;
      rsp_dat_q  <= rsp_dat_n;
      ram_en_n   <= en_n_n;
      ram_wr     <= wr_n;
      ram_add    <= add_n;
      ram_w_data <= wdat_n;
`ifdef RAM_CTRL_INIT_EN
      cnt        <= cnt_n;
      init_done  <= (state_n != ST_INIT);
`endif
    end
  end

`ifndef RAM_CTRL_INIT_EN
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: self-checking bench for ram_ctrl. A behavioural RAM sits on
// the RAM pins; a per-cycle checker predicts every output from transaction
// ages (cycles since accept / since reset) and an intended-memory array;
// directed tests pin latency, pulse counts and data with literal values.
// Covers the RAM_CTRL_INIT_EN build when that macro is defined.
module tb_ram_ctrl;

`ifdef RAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam logic [4:0] IV = 5'h1F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done, ram_en_n, ram_wr;
  logic [1:0] ram_add;
  logic [4:0] ram_w_data, ram_r_data;
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;

  ram_ctrl_if #(.DATA_W(5), .ADDR_W(2)) bus ();

`ifdef RAM_CTRL_INIT_EN
  ram_ctrl #(.DATA_W(5), .ADDR_W(2), .INIT_VAL(IV)) dut (
`else
  ram_ctrl #(.DATA_W(5), .ADDR_W(2)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done),
    .ram_en_n(ram_en_n), .ram_wr(ram_wr), .ram_add(ram_add),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with registered read data.
  logic [4:0] ram_mem [4] = '{5'h08, 5'h09, 5'h0A, 5'h0B};
  always @(posedge clk) begin
    if (ram_en_n === 1'b0) begin
      if (ram_wr === 1'b0) ram_mem[ram_add] <= ram_w_data;
      else                 ram_r_data <= ram_mem[ram_add];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle model: ages count cycles since a request was accepted
  // (1 = first cycle after the accepting edge) or since the reset edge.
  logic [4:0] model_mem [4] = '{5'h08, 5'h09, 5'h0A, 5'h0B};
  bit         started = 1'b0;
  int         rst_age = 0, wr_age = -1, rd_age = -1;
  logic [1:0] wr_a, rd_a;
  logic [4:0] wr_d, rd_exp;
  int         wr_pulses = 0;

  always @(negedge clk) begin : cmp
    bit rdy_e, en_e, init_pulse;
    rdy_e = 1'b0;
    if (started) begin
      init_pulse = INIT_EN && rst_age >= 1 && rst_age <= 4;
      rdy_e = !(rst_age == 0 || (INIT_EN && rst_age < 4) || wr_age == 1 || rd_age >= 1);
      en_e  = init_pulse || wr_age == 1 || rd_age == 1;
      chk("req_ready", 32'(bus.req_ready), 32'(rdy_e));
      chk("ram_en_n", 32'(ram_en_n), 32'(!en_e));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rd_age == 3));
      chk("init_done", 32'(init_done), 32'(!(INIT_EN && rst_age < 4)));
      if (init_pulse) begin
        chk("init_wr", 32'(ram_wr), 32'(0));
        chk("init_add", 32'(ram_add), 32'(rst_age - 1));
        chk("init_data", 32'(ram_w_data), 32'(IV));
      end
      if (wr_age == 1) begin
        chk("wr_op", 32'(ram_wr), 32'(0));
        chk("wr_add", 32'(ram_add), 32'(wr_a));
        chk("wr_data", 32'(ram_w_data), 32'(wr_d));
      end
      if (rd_age == 1) begin
        chk("rd_op", 32'(ram_wr), 32'(1));
        chk("rd_add", 32'(ram_add), 32'(rd_a));
      end
      if (rd_age == 3) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rd_exp));
      if (rst_age == 0) begin
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'(0));
        chk("rst_wr", 32'(ram_wr), 32'(1));
        chk("rst_add", 32'(ram_add), 32'(0));
        chk("rst_wdata", 32'(ram_w_data), 32'(0));
      end
      if (ram_en_n === 1'b0 && ram_wr === 1'b0) wr_pulses++;
    end
    // Predict the effect of the coming edge.
    if (rst_n !== 1'b1) begin
      started = 1'b1;
      rst_age = 0;
      wr_age  = -1;
      rd_age  = -1;
      if (INIT_EN) for (int i = 0; i < 4; i++) model_mem[i] = IV;
    end else if (started) begin
      if (rst_age < 100) rst_age++;
      if (wr_age == 1) wr_age = -1;
      if (rd_age == 3) begin
        if (bus.rsp_ready) rd_age = -1;
      end else if (rd_age >= 1) rd_age++;
      if (bus.req_valid && rdy_e) begin
        if (bus.req_write) begin
          model_mem[bus.req_addr] = bus.req_wdata;
          wr_age = 1; wr_a = bus.req_addr; wr_d = bus.req_wdata;
        end else begin
          rd_age = 1; rd_a = bus.req_addr; rd_exp = model_mem[bus.req_addr];
        end
      end
    end
  end

  // Present a request (called #1 after a posedge); returns the cycle number
  // of the negedge preceding the accepting edge.
  task automatic send(input bit w, input logic [1:0] a, input logic [4:0] d, output int acc);
    bit got = 1'b0;
    acc = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin got = 1'b1; acc = cyc; break; end
      @(posedge clk); #1;
    end
    chk("accept", 32'(got), 32'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = ~a; bus.req_wdata = ~d; bus.req_write = ~w;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [4:0] d, output int lat);
    int acc;
    bit got = 1'b0;
    d = 'x; lat = -1;
    send(1'b0, a, 5'h0, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = cyc - acc; d = bus.rsp_rdata; got = 1'b1; break; end
    end
    chk("rsp_seen", 32'(got), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [4:0] d;
    int lat, acc, p0, k;
    int accs [3];
    logic [4:0] bd [3];
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'(0));
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("reset_ram_en_n", 32'(ram_en_n), 32'(1));
    @(posedge clk); #1;
    repeat (8) @(posedge clk);
    #1;
    chk("init_done_up", 32'(init_done), 32'(1));

    // 1: single write then read back
    p0 = wr_pulses;
    send(1'b1, 2'd2, 5'h15, acc);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_write_pulses", 32'(wr_pulses - p0), 32'(1));
    do_read(2'd2, d, lat);
    chk("t1_rdata", 32'(d), 32'h15);
    chk("t1_latency", 32'(lat), 32'(3));

    // 2: fill all words, read 3 then 0
    for (int i = 0; i < 4; i++) send(1'b1, 2'(i), 5'(i + 1), acc);
    do_read(2'd3, d, lat);
    chk("t2_rd3", 32'(d), 32'h04);
    do_read(2'd0, d, lat);
    chk("t2_rd0", 32'(d), 32'h01);
    chk("t2_latency", 32'(lat), 32'(3));

    // 3: response held while the consumer stalls
    bus.rsp_ready = 1'b0;
    send(1'b0, 2'd1, 5'h0, acc);
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'(1));
      chk("t3_hold_rdata", 32'(bus.rsp_rdata), 32'h02);
      chk("t3_hold_ready", 32'(bus.req_ready), 32'(0));
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_valid", 32'(bus.rsp_valid), 32'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_after_valid", 32'(bus.rsp_valid), 32'(0));
    chk("t3_after_ready", 32'(bus.req_ready), 32'(1));
    @(posedge clk); #1;

    // 4: reset while the read is at the RAM
    send(1'b0, 2'd0, 5'h0, acc);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("t4_ram_en_n", 32'(ram_en_n), 32'(1));
    chk("t4_req_ready", 32'(bus.req_ready), 32'(0));
    @(posedge clk); #1;
    do_read(2'd3, d, lat);
    chk("t4_rd3", 32'(d), INIT_EN ? 32'h1F : 32'h04);

    // 5: req_valid held across three back-to-back writes
    bd[0] = 5'h0A; bd[1] = 5'h0B; bd[2] = 5'h0C;
    p0 = wr_pulses; k = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 2'd0; bus.req_wdata = bd[0];
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin accs[k] = cyc; k++; end
      @(posedge clk); #1;
      if (k < 3) begin bus.req_addr = 2'(k); bus.req_wdata = bd[k]; end
      else bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    chk("t5_accepts", 32'(k), 32'(3));
    chk("t5_gap01", 32'(accs[1] - accs[0]), 32'(2));
    chk("t5_gap12", 32'(accs[2] - accs[1]), 32'(2));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_write_pulses", 32'(wr_pulses - p0), 32'(3));
    do_read(2'd1, d, lat);
    chk("t5_rd1", 32'(d), 32'h0B);

`ifdef RAM_CTRL_INIT_EN
    // 6: init sweep after reset
    p0 = wr_pulses;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("t6_init_pulses", 32'(wr_pulses - p0), 32'(4));
    chk("t6_init_done", 32'(init_done), 32'(1));
    do_read(2'd1, d, lat);
    chk("t6_rd1", 32'(d), 32'h1F);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
